// File: rtl/butterfly_cplx_pipe.sv
// butterfly_cplx_pipe: 3-stage radix-2 DIT complex butterfly y1 = a + b*w, y2 = a - b*w with scaling, bypass and saturation
module butterfly_cplx_pipe #(
   parameter int N = 4,
   parameter int LAT = 3,
   localparam int W = 2**N
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic signed [W-1:0] a_re,
   input  logic signed [W-1:0] a_im,
   input  logic signed [W-1:0] b_re,
   input  logic signed [W-1:0] b_im,
   input  logic signed [W-1:0] w_re,
   input  logic signed [W-1:0] w_im,
   input  logic                scale,
   input  logic                bypass,
   input  logic                clr_ovf,
   output logic signed [W-1:0] y1_re,
   output logic signed [W-1:0] y1_im,
   output logic signed [W-1:0] y2_re,
   output logic signed [W-1:0] y2_im,
   output logic                out_valid,
   output logic                ovf
);
   if (LAT != 3) begin : g_lat_unsupported
      $error("butterfly_cplx_pipe is built for a latency of exactly 3");
   end
   localparam logic signed [2*W:0] RND = (2*W+1)'(1) << (W-2);
   localparam logic signed [W+1:0] HI = {3'b000, {(W-1){1'b1}}};
   localparam logic signed [W+1:0] LO = {3'b111, {(W-1){1'b0}}};
   logic                  v1_q, sc1_q, bp1_q;
   logic signed [W-1:0]   ar1_q, ai1_q, br1_q, bi1_q;
   logic signed [2*W-1:0] prr_q, pii_q, pri_q, pir_q;
   logic                  v2_q, sc2_q;
   logic signed [W-1:0]   ar2_q, ai2_q;
   logic signed [2*W:0]   tr, ti;
   logic signed [W:0]     tr2_d, ti2_d, tr2_q, ti2_q;
   logic signed [W+1:0]   s1r, s1i, s2r, s2i;
   logic [W:0]            q1r, q1i, q2r, q2i;
   logic signed [W-1:0]   y1r_q, y1i_q, y2r_q, y2i_q;
   logic                  out_valid_q, ovf_q, ovf_d;
   function automatic logic signed [W+1:0] scl(input logic sc, input logic signed [W+1:0] s);
      return sc ? (s + (W+2)'(1)) >>> 1 : s;
   endfunction
   // returns {saturated, clamped value}
   function automatic logic [W:0] sat(input logic signed [W+1:0] s);
      return s > HI ? {1'b1, HI[W-1:0]} : s < LO ? {1'b1, LO[W-1:0]} : {1'b0, s[W-1:0]};
   endfunction
   // stage 1: capture a and controls, form the four partial products
   always_ff @(posedge clk) begin
      if (!rst) begin
         {v1_q, sc1_q, bp1_q} <= '0;
         {ar1_q, ai1_q, br1_q, bi1_q} <= '0;
         {prr_q, pii_q, pri_q, pir_q} <= '0;
      end else begin
         v1_q  <= in_valid;
         sc1_q <= scale;
         bp1_q <= bypass;
         ar1_q <= a_re;
         ai1_q <= a_im;
         br1_q <= b_re;
         bi1_q <= b_im;
         prr_q <= (2*W)'(b_re) * (2*W)'(w_re);
         pii_q <= (2*W)'(b_im) * (2*W)'(w_im);
         pri_q <= (2*W)'(b_re) * (2*W)'(w_im);
         pir_q <= (2*W)'(b_im) * (2*W)'(w_re);
      end
   end
   // stage 2 combinational: complex product, round half-up back to Q1 scale, or pass b on bypass
   always_comb begin
      tr    = (2*W+1)'(prr_q) - (2*W+1)'(pii_q);
      ti    = (2*W+1)'(pri_q) + (2*W+1)'(pir_q);
      tr2_d = bp1_q ? (W+1)'(br1_q) : (W+1)'((tr + RND) >>> (W-1));
      ti2_d = bp1_q ? (W+1)'(bi1_q) : (W+1)'((ti + RND) >>> (W-1));
   end
   // stage 2 register: rounded twiddled operand t with a and scale
   always_ff @(posedge clk) begin
      if (!rst) begin
         {v2_q, sc2_q} <= '0;
         {ar2_q, ai2_q, tr2_q, ti2_q} <= '0;
      end else begin
         v2_q  <= v1_q;
         sc2_q <= sc1_q;
         ar2_q <= ar1_q;
         ai2_q <= ai1_q;
         tr2_q <= tr2_d;
         ti2_q <= ti2_d;
      end
   end
   // stage 3 combinational: butterfly sums, optional halving, saturation and overflow update
   always_comb begin
      s1r   = scl(sc2_q, (W+2)'(ar2_q) + (W+2)'(tr2_q));
      s1i   = scl(sc2_q, (W+2)'(ai2_q) + (W+2)'(ti2_q));
      s2r   = scl(sc2_q, (W+2)'(ar2_q) - (W+2)'(tr2_q));
      s2i   = scl(sc2_q, (W+2)'(ai2_q) - (W+2)'(ti2_q));
      q1r   = sat(s1r);
      q1i   = sat(s1i);
      q2r   = sat(s2r);
      q2i   = sat(s2i);
      ovf_d = (v2_q && (q1r[W] || q1i[W] || q2r[W] || q2i[W])) ? 1'b1 : clr_ovf ? 1'b0 : ovf_q;
   end
   // stage 3 register: outputs load only on valid sets and hold otherwise
   always_ff @(posedge clk) begin
      if (!rst) begin
         {out_valid_q, ovf_q} <= '0;
         {y1r_q, y1i_q, y2r_q, y2i_q} <= '0;
      end else begin
         out_valid_q <= v2_q;
         ovf_q       <= ovf_d;
         if (v2_q) begin
            y1r_q <= q1r[W-1:0];
            y1i_q <= q1i[W-1:0];
            y2r_q <= q2r[W-1:0];
            y2i_q <= q2i[W-1:0];
         end
      end
   end
   assign y1_re     = y1r_q;
   assign y1_im     = y1i_q;
   assign y2_re     = y2r_q;
   assign y2_im     = y2i_q;
   assign out_valid = out_valid_q;
   assign ovf       = ovf_q;
endmodule
